// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for a small core: breakpoints, stop causes,
// executed-cycle counter and a two-cycle debug read of data memory.
module cpu_run_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DMEM_AW = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_BP  = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run_req,
    input  logic                     step_req,
    input  logic                     halt_req,
    input  logic                     halt_inst,
    input  logic [ADDR_W-1:0]        curr_inst_addr,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic                     cnt_clr,
    input  logic                     dbg_req,
    input  logic [DMEM_AW-1:0]       dbg_addr,
    input  logic [DATA_W-1:0]        dmem_rd_data,
    output logic                     core_en,
    output logic [1:0]               run_state,
    output logic [2:0]               stop_cause,
    output logic [2:0]               bp_hit_idx,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [DMEM_AW-1:0]       dmem_rd_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     dbg_valid,
    output logic                     dbg_busy,
    output logic                     dbg_err
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP    = 2'd2
    } state_t;

    localparam logic [2:0] CAUSE_NONE = 3'd0;
    localparam logic [2:0] CAUSE_BP   = 3'd1;
    localparam logic [2:0] CAUSE_HALT = 3'd2;
    localparam logic [2:0] CAUSE_EXT  = 3'd3;
    localparam logic [2:0] CAUSE_STEP = 3'd4;

    state_t            state, state_nxt;
    logic              run_first, run_first_nxt;
    logic [2:0]        cause_nxt, idx_nxt;
    logic [NUM_BP-1:0] bp_hits;
    logic [2:0]        bp_low_idx;
    logic              bp_match;

    // Comparator bank; the lowest matching index wins.
    always_comb begin
        bp_hits    = '0;
        bp_low_idx = '0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            bp_hits[i] = bp_en[i] && (bp_addr[i*int'(ADDR_W) +: ADDR_W] == curr_inst_addr);
        end
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bp_hits[i]) bp_low_idx = 3'(i);
        end
    end

    // First RUN cycle is masked so a resume can step off the breakpoint address.
    assign bp_match  = (|bp_hits) && !run_first;
    assign core_en   = (state == ST_STEP) || ((state == ST_RUN) && !bp_match);
    assign run_state = state;

    always_comb begin
        state_nxt     = state;
        cause_nxt     = stop_cause;
        idx_nxt       = bp_hit_idx;
        run_first_nxt = 1'b0;
        unique case (state)
            ST_STOPPED: begin
                if (!dbg_busy) begin
                    if (step_req) begin
                        state_nxt = ST_STEP;
                    end else if (run_req) begin
                        state_nxt     = ST_RUN;
                        run_first_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bp_match) begin
                    state_nxt = ST_STOPPED;
                    cause_nxt = CAUSE_BP;
                    idx_nxt   = bp_low_idx;
                end else if (halt_inst) begin
                    state_nxt = ST_STOPPED;
                    cause_nxt = CAUSE_HALT;
                end else if (halt_req) begin
                    state_nxt = ST_STOPPED;
                    cause_nxt = CAUSE_EXT;
                end
            end
            ST_STEP: begin
                state_nxt = ST_STOPPED;
                cause_nxt = halt_inst ? CAUSE_HALT : CAUSE_STEP;
            end
            default: begin
                state_nxt = ST_STOPPED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_STOPPED;
            run_first  <= 1'b0;
            stop_cause <= CAUSE_NONE;
            bp_hit_idx <= '0;
        end else begin
            state      <= state_nxt;
            run_first  <= run_first_nxt;
            stop_cause <= cause_nxt;
            bp_hit_idx <= idx_nxt;
        end
    end

    // Saturating executed-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (cnt_clr) begin
            cycle_count <= '0;
        end else if (core_en && (cycle_count != {CNT_W{1'b1}})) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    // Debug read: address registered on accept, data captured one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_rd_addr <= '0;
            dbg_data     <= '0;
            dbg_valid    <= 1'b0;
            dbg_busy     <= 1'b0;
            dbg_err      <= 1'b0;
        end else begin
            dbg_valid <= 1'b0;
            dbg_err   <= 1'b0;
            if (dbg_busy) begin
                dbg_data  <= dmem_rd_data;
                dbg_valid <= 1'b1;
                dbg_busy  <= 1'b0;
            end else if (dbg_req) begin
                if (state == ST_STOPPED) begin
                    dmem_rd_addr <= dbg_addr;
                    dbg_busy     <= 1'b1;
                end else begin
                    dbg_err <= 1'b1;
                end
            end
        end
    end

endmodule
